ht_sequencer: RTL and testbench
===============================

HT_SEQUENCER -- requirements
Module: ht_sequencer

Interface
REQ-001 Parameter LENGTH, default 27: FIR tap count; sets coefficient-load window, fill and flush lengths.
REQ-002 Parameter DATA_WIDTH, default 18: sample width.
REQ-003 Port clock, input, 1, sole clock; all logic rising-edge.
REQ-004 Port resetn, input, 1, asynchronous active-low reset.
REQ-005 Port enable, input, 1, level request to run the Hilbert datapath.
REQ-006 Port stopDataInFlag, input, 1, end-of-stream request.
REQ-007 Port inValid, input, 1, dataIn qualifier.
REQ-008 Port dataIn, input, DATA_WIDTH signed, input sample.
REQ-009 Port coeffSetFlag, input, 1, coefficient source reports all LENGTH coefficients delivered.
REQ-010 Port loadCoeff, output, 1, enables the coefficient source and FIR coefficient shift.
REQ-011 Port coeffStartFlag, output, 1, one-cycle pulse marking the coefficient-load start.
REQ-012 Port loadDataFlag, output, 1, FIR data-load enable.
REQ-013 Port stopDataLoadFlag, output, 1, one-cycle FIR stop pulse.
REQ-014 Port dataFIRIn, output, DATA_WIDTH signed, sample to FIR.
REQ-015 Port outValid, output, 1, FIR/real-path output qualifier.
REQ-016 Port coeffError, output, 1, sticky coefficient-load timeout.
REQ-017 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE=0, LOAD_COEFF=1, FILL=2, RUN=3, FLUSH=4, DONE=5; 3-bit encoding; codes 6-7 return to IDLE with reset outputs.
REQ-019 IDLE, enable=1: next state LOAD_COEFF; loadCoeff=1; coeffStartFlag=1 for exactly that cycle; coeffCnt cleared; coeffError cleared.
REQ-020 LOAD_COEFF: coeffCnt +1 per cycle; coeffSetFlag=1 -> FILL, loadCoeff=0, loadDataFlag=1, sampleCnt cleared.
REQ-021 LOAD_COEFF: coeffCnt reaching LENGTH+4 without coeffSetFlag -> coeffError=1, loadCoeff=0, IDLE; coeffSetFlag in the same cycle wins.
REQ-022 FILL/RUN: dataFIRIn <= dataIn when inValid=1, else dataFIRIn holds; exactly 1-cycle latency.
REQ-023 FILL: sampleCnt +1 per accepted sample; the LENGTH-th accepted sample -> RUN; outValid=0 throughout FILL.
REQ-024 RUN: outValid <= inValid (registered, aligned with dataFIRIn).
REQ-025 stopDataInFlag=1 in FILL or RUN: priority over inValid (sample dropped); next state FLUSH when HT_SEQ_FLUSH_EN is defined, else DONE.
REQ-026 FLUSH: dataFIRIn=0, outValid=1 for exactly LENGTH cycles (counter), then DONE.
REQ-027 DONE: stopDataLoadFlag=1, loadDataFlag=0, outValid=0, dataFIRIn=0 for one cycle; then IDLE.
REQ-028 enable=0 in LOAD_COEFF, FILL, RUN or FLUSH: abort, loadCoeff=0, next state DONE (no flush); takes priority over stopDataInFlag.
REQ-029 Counters saturate, never wrap; width clog2(LENGTH+5).

Reset
REQ-030 resetn=0: state=IDLE, all counters 0, all outputs 0 (including coeffError and dataFIRIn), regardless of state.
REQ-031 Reset deassertion with enable=1: first transition occurs on the first rising edge after release.

Configuration
REQ-032 Macro HT_SEQ_FLUSH_EN defined: FLUSH state present per REQ-026.
REQ-033 HT_SEQ_FLUSH_EN undefined: FLUSH logic and counter absent; stop goes directly to DONE; code 4 is treated as illegal.

Structure
REQ-034 Shared package ht_pkg holds the state encoding constants and the default LENGTH/DATA_WIDTH.
REQ-035 One sub-module, ht_seq_counter (saturating, clear/enable, parameterised limit), is instantiated for coeffCnt, sampleCnt and flushCnt.

Verification
REQ-036 LENGTH=27, enable=1, coeffSetFlag at cycle 27 -> coeffStartFlag for 1 cycle, loadCoeff high 27 cycles, then loadDataFlag=1.
REQ-037 Stream 40 valid samples 1..40 -> outValid first high with sample 27 on dataFIRIn; samples 28..40 follow 1 cycle after input.
REQ-038 stopDataInFlag with inValid in RUN, FLUSH_EN defined -> sample dropped, 27 zero cycles with outValid=1, stopDataLoadFlag pulse, IDLE; undefined -> DONE next cycle.
REQ-039 coeffSetFlag never asserted -> coeffError=1 after 31 LOAD_COEFF cycles, busy=0; next enable clears it.
REQ-040 resetn pulsed low mid-RUN and mid-FLUSH -> all outputs 0 immediately, state IDLE.
REQ-041 enable dropped during FILL with stopDataInFlag=1 -> DONE (no FLUSH), stopDataLoadFlag pulse, IDLE.

Source files
------------

// File: rtl/ht_pkg.sv
// Shared definitions for the Hilbert-transform FIR sequencer: state codes and default sizing.
package ht_pkg;

    localparam int HT_LENGTH     = 27;
    localparam int HT_DATA_WIDTH = 18;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_COEFF = 3'd1,
        ST_FILL       = 3'd2,
        ST_RUN        = 3'd3,
        ST_FLUSH      = 3'd4,
        ST_DONE       = 3'd5
    } ht_state_e;

endpackage

// File: rtl/ht_seq_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable); holds at LIMIT.
module ht_seq_counter #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 31
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != MAX)
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ht_sequencer.sv
// Control sequencer for the Hilbert FIR: coefficient load, fill, run, optional flush, done.
// Define HT_SEQ_FLUSH_EN to push LENGTH zero samples through the FIR after a stop request.
module ht_sequencer
    import ht_pkg::*;
#(
    parameter int LENGTH     = HT_LENGTH,
    parameter int DATA_WIDTH = HT_DATA_WIDTH
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         stopDataInFlag,
    input  logic                         inValid,
    input  logic signed [DATA_WIDTH-1:0] dataIn,
    input  logic                         coeffSetFlag,
    output logic                         loadCoeff,
    output logic                         coeffStartFlag,
    output logic                         loadDataFlag,
    output logic                         stopDataLoadFlag,
    output logic signed [DATA_WIDTH-1:0] dataFIRIn,
    output logic                         outValid,
    output logic                         coeffError,
    output logic                         busy
);
    localparam int CW = $clog2(LENGTH + 5);
    localparam logic [CW-1:0] COEFF_LAST  = CW'(LENGTH + 3);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(LENGTH - 1);

    ht_state_e state_q, state_d;
    logic load_coeff_q, load_coeff_d;
    logic start_q, start_d;
    logic load_data_q, load_data_d;
    logic stop_load_q, stop_load_d;
    logic out_valid_q, out_valid_d;
    logic error_q, error_d;
    logic busy_q, busy_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;

    logic [CW-1:0] coeff_cnt, sample_cnt;
    logic sample_take, fill_last, go_done;

    assign sample_take = (state_q == ST_FILL) && enable && !stopDataInFlag && inValid;
    assign fill_last   = sample_take && (sample_cnt == SAMPLE_LAST);

    // Counters clear whenever their state is not active, so each entry starts at zero.
    ht_seq_counter #(.WIDTH(CW), .LIMIT(LENGTH + 4)) u_coeff_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (state_q != ST_LOAD_COEFF),
        .en     (state_q == ST_LOAD_COEFF),
        .cnt    (coeff_cnt)
    );

    ht_seq_counter #(.WIDTH(CW), .LIMIT(LENGTH)) u_sample_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (state_q != ST_FILL),
        .en     (sample_take),
        .cnt    (sample_cnt)
    );

`ifdef HT_SEQ_FLUSH_EN
    localparam logic [CW-1:0] FLUSH_LAST = CW'(LENGTH - 1);
    logic [CW-1:0] flush_cnt;

    ht_seq_counter #(.WIDTH(CW), .LIMIT(LENGTH)) u_flush_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (state_q != ST_FLUSH),
        .en     (state_q == ST_FLUSH),
        .cnt    (flush_cnt)
    );
`endif

    always_comb begin
        state_d      = state_q;
        load_coeff_d = load_coeff_q;
        start_d      = 1'b0;
        load_data_d  = load_data_q;
        stop_load_d  = 1'b0;
        out_valid_d  = out_valid_q;
        data_d       = data_q;
        error_d      = error_q;
        go_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d      = ST_LOAD_COEFF;
                    load_coeff_d = 1'b1;
                    start_d      = 1'b1;
                    error_d      = 1'b0;
                end
            end
            ST_LOAD_COEFF: begin
                if (!enable) begin
                    go_done = 1'b1;
                end else if (coeffSetFlag) begin
                    state_d      = ST_FILL;
                    load_coeff_d = 1'b0;
                    load_data_d  = 1'b1;
                    out_valid_d  = 1'b0;
                end else if (coeff_cnt == COEFF_LAST) begin
                    state_d      = ST_IDLE;
                    load_coeff_d = 1'b0;
                    error_d      = 1'b1;
                end
            end
            ST_FILL, ST_RUN: begin
                if (!enable) begin
                    go_done = 1'b1;
                end else if (stopDataInFlag) begin
`ifdef HT_SEQ_FLUSH_EN
                    state_d     = ST_FLUSH;
                    data_d      = '0;
                    out_valid_d = 1'b1;
`else
                    go_done = 1'b1;
`endif
                end else begin
                    if (inValid)
                        data_d = dataIn;
                    if (state_q == ST_RUN) begin
                        out_valid_d = inValid;
                    end else begin
                        // The sample that completes the fill is the first one qualified.
                        out_valid_d = fill_last;
                        if (fill_last)
                            state_d = ST_RUN;
                    end
                end
            end
`ifdef HT_SEQ_FLUSH_EN
            ST_FLUSH: begin
                if (!enable || flush_cnt == FLUSH_LAST)
                    go_done = 1'b1;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                load_coeff_d = 1'b0;
                load_data_d  = 1'b0;
                out_valid_d  = 1'b0;
                data_d       = '0;
                error_d      = 1'b0;
            end
        endcase
        if (go_done) begin
            state_d      = ST_DONE;
            load_coeff_d = 1'b0;
            load_data_d  = 1'b0;
            out_valid_d  = 1'b0;
            data_d       = '0;
            stop_load_d  = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            load_coeff_q <= 1'b0;
            start_q      <= 1'b0;
            load_data_q  <= 1'b0;
            stop_load_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            load_coeff_q <= load_coeff_d;
            start_q      <= start_d;
            load_data_q  <= load_data_d;
            stop_load_q  <= stop_load_d;
            out_valid_q  <= out_valid_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            data_q       <= data_d;
        end
    end

    assign loadCoeff        = load_coeff_q;
    assign coeffStartFlag   = start_q;
    assign loadDataFlag     = load_data_q;
    assign stopDataLoadFlag = stop_load_q;
    assign outValid         = out_valid_q;
    assign coeffError       = error_q;
    assign busy             = busy_q;
    assign dataFIRIn        = data_q;

endmodule

// File: tb/tb_ht_sequencer.sv
// Bench for ht_sequencer: directed table, multi-cycle sequences and random traffic vs a phase model.
module tb_ht_sequencer;
    localparam int LENGTH = 27;
    localparam int DW     = 18;
`ifdef HT_SEQ_FLUSH_EN
    localparam int FLUSH_CYC = LENGTH;
`else
    localparam int FLUSH_CYC = 0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b1;
    logic enable = 1'b0, stopDataInFlag = 1'b0, inValid = 1'b0, coeffSetFlag = 1'b0;
    logic signed [DW-1:0] dataIn = '0;
    logic loadCoeff, coeffStartFlag, loadDataFlag, stopDataLoadFlag, outValid, coeffError, busy;
    logic signed [DW-1:0] dataFIRIn;

    always #5 clock = ~clock;

    ht_sequencer #(.LENGTH(LENGTH), .DATA_WIDTH(DW)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .enable           (enable),
        .stopDataInFlag   (stopDataInFlag),
        .inValid          (inValid),
        .dataIn           (dataIn),
        .coeffSetFlag     (coeffSetFlag),
        .loadCoeff        (loadCoeff),
        .coeffStartFlag   (coeffStartFlag),
        .loadDataFlag     (loadDataFlag),
        .stopDataLoadFlag (stopDataLoadFlag),
        .dataFIRIn        (dataFIRIn),
        .outValid         (outValid),
        .coeffError       (coeffError),
        .busy             (busy)
    );

    typedef struct packed { logic en; logic stop; logic iv; logic cset; logic [DW-1:0] din; } in_t;
    typedef struct packed { logic lc; logic st; logic ld; logic sp; logic ov; logic er; logic bz; logic [DW-1:0] d; } out_t;
    typedef struct packed { in_t i; out_t o; } vec_t;

    int n_vec = 0, n_bad = 0;

    // Reference model: what the sequencer is doing, tracked as phase plus event tallies.
    typedef enum int {P_IDLE, P_COEFF, P_FILL, P_RUN, P_FLUSH, P_DONE} phase_e;
    phase_e ph = P_IDLE;
    int load_cycles = 0, filled = 0, flush_left = 0;
    out_t m = '0;

    function automatic out_t dut_out();
        out_t o;
        o.lc = loadCoeff;  o.st = coeffStartFlag; o.ld = loadDataFlag; o.sp = stopDataLoadFlag;
        o.ov = outValid;   o.er = coeffError;     o.bz = busy;         o.d  = dataFIRIn;
        return o;
    endfunction

    task automatic check_out(input string nm, input out_t exp);
        out_t g;
        g = dut_out();
        n_vec++;
        if (g !== exp) begin
            n_bad++;
            $display("FAIL %s: got lc=%b st=%b ld=%b sp=%b ov=%b er=%b busy=%b d=%0d, expected lc=%b st=%b ld=%b sp=%b ov=%b er=%b busy=%b d=%0d",
                     nm, g.lc, g.st, g.ld, g.sp, g.ov, g.er, g.bz, $signed(g.d),
                     exp.lc, exp.st, exp.ld, exp.sp, exp.ov, exp.er, exp.bz, $signed(exp.d));
        end
    endtask

    task automatic check_val(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic end_run();
        ph = P_DONE; m.lc = 1'b0; m.ld = 1'b0; m.ov = 1'b0; m.d = '0; m.sp = 1'b1;
    endtask

    task automatic model_edge(input in_t i);
        m.st = 1'b0;
        m.sp = 1'b0;
        case (ph)
            P_IDLE: if (i.en) begin ph = P_COEFF; m.lc = 1'b1; m.st = 1'b1; m.er = 1'b0; load_cycles = 0; end
            P_COEFF: begin
                load_cycles++;
                if (!i.en) end_run();
                else if (i.cset) begin ph = P_FILL; m.lc = 1'b0; m.ld = 1'b1; filled = 0; end
                else if (load_cycles == LENGTH + 4) begin ph = P_IDLE; m.lc = 1'b0; m.er = 1'b1; end
            end
            P_FILL, P_RUN: begin
                if (!i.en) end_run();
                else if (i.stop) begin
                    if (FLUSH_CYC > 0) begin ph = P_FLUSH; m.d = '0; m.ov = 1'b1; flush_left = FLUSH_CYC; end
                    else end_run();
                end else if (ph == P_RUN) begin
                    m.ov = i.iv;
                    if (i.iv) m.d = i.din;
                end else if (i.iv) begin
                    m.d = i.din;
                    filled++;
                    if (filled == LENGTH) begin ph = P_RUN; m.ov = 1'b1; end
                end
            end
            P_FLUSH: begin
                flush_left--;
                if (!i.en || flush_left == 0) end_run();
            end
            default: ph = P_IDLE;
        endcase
        m.bz = (ph != P_IDLE);
    endtask

    task automatic apply(input in_t i, input string nm, input bit use_tab, input out_t tab);
        enable = i.en; stopDataInFlag = i.stop; inValid = i.iv; coeffSetFlag = i.cset; dataIn = i.din;
        @(posedge clock);
        model_edge(i);
        #1;
        check_out(nm, use_tab ? tab : m);
    endtask

    task automatic cyc(input logic en, input logic stop, input logic iv, input logic cset, input int din, input string nm);
        in_t i;
        i.en = en; i.stop = stop; i.iv = iv; i.cset = cset; i.din = DW'(din);
        apply(i, nm, 1'b0, '0);
    endtask

    task automatic do_reset(input string nm, input logic en_rel);
        #1;
        resetn = 1'b0; enable = 1'b0; stopDataInFlag = 1'b0; inValid = 1'b0; coeffSetFlag = 1'b0; dataIn = '0;
        #1;
        check_out(nm, '0);
        ph = P_IDLE; m = '0;
        @(posedge clock);
        #1;
        enable = en_rel;
        resetn = 1'b1;
    endtask

    // flags = {lc, st, ld, sp, ov, er, busy}
    function automatic vec_t V(input logic en, input logic stop, input logic iv, input logic cset,
                               input int din, input logic [6:0] flags, input int d);
        vec_t v;
        v.i.en = en; v.i.stop = stop; v.i.iv = iv; v.i.cset = cset; v.i.din = DW'(din);
        v.o = {flags, DW'(d)};
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab [14];
        int lc_n, st_n, ov_n, sp_n, first_d;
        bit seen;
        logic en_r;

        do_reset("reset state", 1'b0);

        tab[0]  = V(0,0,0,0,  0, 7'b0000000, 0);
        tab[1]  = V(1,0,0,0,  0, 7'b1100001, 0);
        tab[2]  = V(1,0,0,0,  0, 7'b1000001, 0);
        tab[3]  = V(1,0,0,1,  0, 7'b0010001, 0);
        tab[4]  = V(1,0,1,0,  5, 7'b0010001, 5);
        tab[5]  = V(1,0,0,0,  9, 7'b0010001, 5);
        tab[6]  = V(0,1,1,0,  7, 7'b0001001, 0);
        tab[7]  = V(0,0,0,0,  0, 7'b0000000, 0);
        tab[8]  = V(1,1,0,0,  0, 7'b1100001, 0);
        tab[9]  = V(0,0,0,1,  0, 7'b0001001, 0);
        tab[10] = V(0,0,0,0,  0, 7'b0000000, 0);
        tab[11] = V(1,0,0,0, -3, 7'b1100001, 0);
        tab[12] = V(0,0,1,0,  0, 7'b0001001, 0);
        tab[13] = V(0,0,0,0,  0, 7'b0000000, 0);
        foreach (tab[k]) apply(tab[k].i, $sformatf("table[%0d]", k), 1'b1, tab[k].o);

        // Release with enable high, coefficients report done in the 27th load cycle.
        do_reset("reset before load", 1'b1);
        lc_n = 0; st_n = 0;
        for (int k = 0; k < 28; k++) begin
            cyc(1, 0, 0, (k == 27), 0, "coeff load");
            lc_n += int'(loadCoeff);
            st_n += int'(coeffStartFlag);
        end
        check_val("loadCoeff cycles", lc_n, 27);
        check_val("coeffStartFlag cycles", st_n, 1);
        check_val("loadDataFlag after load", int'(loadDataFlag), 1);

        seen = 1'b0; first_d = 0; ov_n = 0;
        for (int s = 1; s <= 40; s++) begin
            cyc(1, 0, 1, 0, s, "stream");
            if (outValid && !seen) begin seen = 1'b1; first_d = int'(dataFIRIn); end
            ov_n += int'(outValid);
        end
        check_val("first qualified sample", first_d, 27);
        check_val("qualified sample count", ov_n, 14);

        ov_n = 0; sp_n = 0;
        cyc(1, 1, 1, 0, 99, "stop in run");
        ov_n += int'(outValid && dataFIRIn == 0);
        sp_n += int'(stopDataLoadFlag);
        for (int j = 1; j <= LENGTH + 2; j++) begin
            cyc(j <= FLUSH_CYC, 0, 0, 0, 0, "flush");
            ov_n += int'(outValid && dataFIRIn == 0);
            sp_n += int'(stopDataLoadFlag);
        end
        check_val("flush zero cycles", ov_n, FLUSH_CYC);
        check_val("stop pulse count", sp_n, 1);
        check_val("busy after stop", int'(busy), 0);

        lc_n = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1, 0, 0, 0, 0, "coeff timeout");
            lc_n += int'(loadCoeff);
        end
        check_val("timeout loadCoeff cycles", lc_n, 31);
        check_val("coeffError set", int'(coeffError), 1);
        check_val("busy after timeout", int'(busy), 0);
        cyc(0, 0, 0, 0, 0, "error sticky");
        check_val("coeffError sticky", int'(coeffError), 1);
        cyc(1, 0, 0, 0, 0, "restart");
        check_val("coeffError cleared", int'(coeffError), 0);
        cyc(0, 0, 0, 0, 0, "abort load");
        cyc(0, 0, 0, 0, 0, "idle");

        cyc(1, 0, 0, 0, 0, "start");
        cyc(1, 0, 0, 1, 0, "coeff set");
        for (int s = 0; s < 30; s++) cyc(1, 0, 1, 0, s * 7 - 50, "fill/run");
        do_reset("reset mid-run", 1'b0);
        cyc(0, 0, 0, 0, 0, "idle after reset");

        cyc(1, 0, 0, 0, 0, "start");
        cyc(1, 0, 0, 1, 0, "coeff set");
        for (int s = 0; s < 28; s++) cyc(1, 0, 1, 0, s + 100, "fill/run");
        cyc(1, 1, 0, 0, 0, "stop");
        for (int s = 0; s < 5; s++) cyc(1, 0, 0, 0, 0, "flushing");
        do_reset("reset mid-flush", 1'b0);
        cyc(0, 0, 0, 0, 0, "idle after reset");

        en_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (en_r && $urandom_range(0, 149) == 0) en_r = 1'b0;
            else if (!en_r && $urandom_range(0, 9) == 0) en_r = 1'b1;
            cyc(en_r, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 11) == 0, int'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
